// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the single-bus CPU control sequencer: opcodes, ALU codes,
// step states, bus/enable bit positions and opcode classification helpers.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        T7   = 4'd7,
        HALT = 4'd8
    } state_t;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHL  = 5'd8;
    localparam logic [4:0] OP_ROR  = 5'd9;
    localparam logic [4:0] OP_ROL  = 5'd10;
    localparam logic [4:0] OP_ADDI = 5'd11;
    localparam logic [4:0] OP_ANDI = 5'd12;
    localparam logic [4:0] OP_ORI  = 5'd13;
    localparam logic [4:0] OP_MUL  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_NEG  = 5'd16;
    localparam logic [4:0] OP_NOT  = 5'd17;
    localparam logic [4:0] OP_BR   = 5'd18;
    localparam logic [4:0] OP_MFHI = 5'd23;
    localparam logic [4:0] OP_MFLO = 5'd24;
    localparam logic [4:0] OP_NOP  = 5'd25;
    localparam logic [4:0] OP_HALT = 5'd26;

    localparam logic [5:0] ALU_NONE = 6'd0;
    localparam logic [5:0] ALU_ADD  = 6'd1;
    localparam logic [5:0] ALU_SUB  = 6'd2;
    localparam logic [5:0] ALU_AND  = 6'd3;
    localparam logic [5:0] ALU_OR   = 6'd4;
    localparam logic [5:0] ALU_SHR  = 6'd5;
    localparam logic [5:0] ALU_SHL  = 6'd6;
    localparam logic [5:0] ALU_ROR  = 6'd7;
    localparam logic [5:0] ALU_ROL  = 6'd8;
    localparam logic [5:0] ALU_MUL  = 6'd9;
    localparam logic [5:0] ALU_DIV  = 6'd10;
    localparam logic [5:0] ALU_NEG  = 6'd11;
    localparam logic [5:0] ALU_NOT  = 6'd12;

    localparam int OS_HI  = 16;
    localparam int OS_LO  = 17;
    localparam int OS_ZHI = 18;
    localparam int OS_ZLO = 19;
    localparam int OS_PC  = 20;
    localparam int OS_MDR = 22;
    localparam int OS_C   = 24;

    localparam int RE_HI  = 16;
    localparam int RE_LO  = 17;
    localparam int RE_ZHI = 18;
    localparam int RE_ZLO = 19;
    localparam int RE_PC  = 20;
    localparam int RE_IR  = 21;
    localparam int RE_MDR = 22;
    localparam int RE_MAR = 23;
    localparam int RE_Y   = 24;

    localparam logic [3:0] GR_SEL = 4'b0001;

    // Instruction classes sharing one execute sequence
    typedef enum logic [3:0] {
        CAT_RR, CAT_IMM, CAT_UN, CAT_LDI, CAT_LD, CAT_ST, CAT_MD,
        CAT_BR, CAT_MFHI, CAT_MFLO, CAT_NOP, CAT_HALT, CAT_ILL
    } cat_t;

    function automatic cat_t op_cat(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: return CAT_RR;
            OP_ADDI, OP_ANDI, OP_ORI:       return CAT_IMM;
            OP_NEG, OP_NOT:                 return CAT_UN;
            OP_LDI:                         return CAT_LDI;
            OP_LD:                          return CAT_LD;
            OP_ST:                          return CAT_ST;
            OP_MUL, OP_DIV:                 return CAT_MD;
            OP_BR:                          return CAT_BR;
            OP_MFHI:                        return CAT_MFHI;
            OP_MFLO:                        return CAT_MFLO;
            OP_NOP:                         return CAT_NOP;
            OP_HALT:                        return CAT_HALT;
            default:                        return CAT_ILL;
        endcase
    endfunction

    function automatic logic [5:0] op_alu(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI: return ALU_ADD;
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR, OP_ORI:   return ALU_OR;
            OP_SHR:          return ALU_SHR;
            OP_SHL:          return ALU_SHL;
            OP_ROR:          return ALU_ROR;
            OP_ROL:          return ALU_ROL;
            OP_MUL:          return ALU_MUL;
            OP_DIV:          return ALU_DIV;
            OP_NEG:          return ALU_NEG;
            OP_NOT:          return ALU_NOT;
            default:         return ALU_NONE;
        endcase
    endfunction

    function automatic state_t last_step(input cat_t c);
        case (c)
            CAT_RR, CAT_IMM, CAT_LDI: return T5;
            CAT_UN:                   return T4;
            CAT_LD, CAT_ST:           return T7;
            CAT_MD, CAT_BR:           return T6;
            default:                  return T3;
        endcase
    endfunction

endpackage

// File: rtl/cpu_control_unit_decode.sv
// Pure combinational map from (step, opcode, con_ff) to the datapath control strobes.
module ctrl_step_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t      i_state,
    input  logic [4:0]  i_opcode,
    input  logic        i_con_ff,
    output logic [31:0] o_out_sel,
    output logic [31:0] o_reg_enable,
    output logic [5:0]  o_alu_sel,
    output logic        o_read,
    output logic        o_write,
    output logic        o_inc_pc,
    output logic [3:0]  o_gra,
    output logic [3:0]  o_grb,
    output logic [3:0]  o_grc,
    output logic        o_rin,
    output logic        o_rout,
    output logic        o_baout,
    output logic        o_con_in,
    output logic        o_run,
    output logic        o_illegal_op
);

    cat_t       w_cat;
    logic [5:0] w_alu;

    assign w_cat = op_cat(i_opcode);
    assign w_alu = op_alu(i_opcode);

    // Strobe decode per step; anything not named in a step stays 0
    always_comb begin
        o_out_sel    = 32'd0;
        o_reg_enable = 32'd0;
        o_alu_sel    = ALU_NONE;
        o_read       = 1'b0;
        o_write      = 1'b0;
        o_inc_pc     = 1'b0;
        o_gra        = 4'd0;
        o_grb        = 4'd0;
        o_grc        = 4'd0;
        o_rin        = 1'b0;
        o_rout       = 1'b0;
        o_baout      = 1'b0;
        o_con_in     = 1'b0;
        o_illegal_op = 1'b0;
        o_run        = (i_state != HALT);
        case (i_state)
            T0: begin
                o_out_sel[OS_PC]     = 1'b1;
                o_reg_enable[RE_MAR] = 1'b1;
                o_inc_pc             = 1'b1;
            end
            T1: begin
                o_read               = 1'b1;
                o_reg_enable[RE_MDR] = 1'b1;
            end
            T2: begin
                o_out_sel[OS_MDR]   = 1'b1;
                o_reg_enable[RE_IR] = 1'b1;
            end
            T3: begin
                case (w_cat)
                    CAT_RR, CAT_IMM: begin
                        o_grb = GR_SEL; o_rout = 1'b1; o_reg_enable[RE_Y] = 1'b1;
                    end
                    CAT_LDI, CAT_LD, CAT_ST: begin
                        o_grb = GR_SEL; o_baout = 1'b1; o_reg_enable[RE_Y] = 1'b1;
                    end
                    CAT_UN: begin
                        o_grb = GR_SEL; o_rout = 1'b1; o_alu_sel = w_alu;
                        o_reg_enable[RE_ZLO:RE_ZHI] = 2'b11;
                    end
                    CAT_MD: begin
                        o_gra = GR_SEL; o_rout = 1'b1; o_reg_enable[RE_Y] = 1'b1;
                    end
                    CAT_BR: begin
                        o_gra = GR_SEL; o_rout = 1'b1; o_con_in = 1'b1;
                    end
                    CAT_MFHI: begin
                        o_out_sel[OS_HI] = 1'b1; o_gra = GR_SEL; o_rin = 1'b1;
                    end
                    CAT_MFLO: begin
                        o_out_sel[OS_LO] = 1'b1; o_gra = GR_SEL; o_rin = 1'b1;
                    end
                    CAT_ILL: o_illegal_op = 1'b1;
                    default: o_illegal_op = 1'b0;
                endcase
            end
            T4: begin
                case (w_cat)
                    CAT_RR: begin
                        o_grc = GR_SEL; o_rout = 1'b1; o_alu_sel = w_alu;
                        o_reg_enable[RE_ZLO:RE_ZHI] = 2'b11;
                    end
                    CAT_IMM: begin
                        o_out_sel[OS_C] = 1'b1; o_alu_sel = w_alu;
                        o_reg_enable[RE_ZLO:RE_ZHI] = 2'b11;
                    end
                    CAT_LDI, CAT_LD, CAT_ST: begin
                        o_out_sel[OS_C] = 1'b1; o_alu_sel = ALU_ADD;
                        o_reg_enable[RE_ZLO:RE_ZHI] = 2'b11;
                    end
                    CAT_UN: begin
                        o_out_sel[OS_ZLO] = 1'b1; o_gra = GR_SEL; o_rin = 1'b1;
                    end
                    CAT_MD: begin
                        o_grb = GR_SEL; o_rout = 1'b1; o_alu_sel = w_alu;
                        o_reg_enable[RE_ZLO:RE_ZHI] = 2'b11;
                    end
                    CAT_BR: begin
                        o_out_sel[OS_PC] = 1'b1; o_reg_enable[RE_Y] = 1'b1;
                    end
                    default: o_rout = 1'b0;
                endcase
            end
            T5: begin
                case (w_cat)
                    CAT_RR, CAT_IMM, CAT_LDI: begin
                        o_out_sel[OS_ZLO] = 1'b1; o_gra = GR_SEL; o_rin = 1'b1;
                    end
                    CAT_LD, CAT_ST: begin
                        o_out_sel[OS_ZLO] = 1'b1; o_reg_enable[RE_MAR] = 1'b1;
                    end
                    CAT_MD: begin
                        o_out_sel[OS_ZLO] = 1'b1; o_reg_enable[RE_LO] = 1'b1;
                    end
                    CAT_BR: begin
                        o_out_sel[OS_C] = 1'b1; o_alu_sel = ALU_ADD;
                        o_reg_enable[RE_ZLO:RE_ZHI] = 2'b11;
                    end
                    default: o_rout = 1'b0;
                endcase
            end
            T6: begin
                case (w_cat)
                    CAT_LD: begin
                        o_read = 1'b1; o_reg_enable[RE_MDR] = 1'b1;
                    end
                    // read stays low so the MDR mux takes the bus, not memory
                    CAT_ST: begin
                        o_gra = GR_SEL; o_rout = 1'b1; o_reg_enable[RE_MDR] = 1'b1;
                    end
                    CAT_MD: begin
                        o_out_sel[OS_ZHI] = 1'b1; o_reg_enable[RE_HI] = 1'b1;
                    end
                    CAT_BR: begin
                        if (i_con_ff) begin
                            o_out_sel[OS_ZLO] = 1'b1; o_reg_enable[RE_PC] = 1'b1;
                        end else begin
                            o_reg_enable[RE_PC] = 1'b0;
                        end
                    end
                    default: o_rout = 1'b0;
                endcase
            end
            T7: begin
                case (w_cat)
                    CAT_LD: begin
                        o_out_sel[OS_MDR] = 1'b1; o_gra = GR_SEL; o_rin = 1'b1;
                    end
                    CAT_ST:  o_write = 1'b1;
                    default: o_write = 1'b0;
                endcase
            end
            default: o_run = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Control sequencer top: holds the step register and next-step logic; strobes come
// from ctrl_step_decode and are forced quiet while clr is asserted.
module cpu_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW             = 5,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic [31:0] out_sel,
    output logic [31:0] reg_enable,
    output logic [5:0]  ALU_Sel,
    output logic        read,
    output logic        write,
    output logic        incPC,
    output logic [3:0]  Gra,
    output logic [3:0]  Grb,
    output logic [3:0]  Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        conIn,
    output logic        run,
    output logic        illegal_op,
    output logic [3:0]  step
);

    state_t      r_state;
    state_t      w_next;
    cat_t        w_cat;
    logic [4:0]  w_opcode;
    logic        w_unused_ir;
    logic [31:0] w_out_sel, w_reg_enable;
    logic [5:0]  w_alu_sel;
    logic [3:0]  w_gra, w_grb, w_grc;
    logic        w_read, w_write, w_inc_pc, w_rin, w_rout, w_baout, w_con_in;
    logic        w_run, w_illegal_op;

    assign w_opcode    = ir[31 -: OPW];
    assign w_cat       = op_cat(w_opcode);
    // Register fields are decoded by the datapath's Select/Encode logic, not here
    assign w_unused_ir = ^ir[31-OPW:0];

    // Next-step selection: fetch runs T0..T2, execute ends at the class's last step
    always_comb begin
        w_next = T0;
        if (r_state == HALT) begin
            w_next = HALT;
        end else if (r_state == T3 && w_cat == CAT_HALT) begin
            w_next = HALT;
        end else if (r_state == T3 && w_cat == CAT_ILL && HALT_ON_ILLEGAL) begin
            w_next = HALT;
        end else if (r_state == T7 || r_state >= last_step(w_cat)) begin
            w_next = T0;
        end else begin
            w_next = state_t'(r_state + 4'd1);
        end
    end

    // Step register with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= T0;
        end else begin
            r_state <= w_next;
        end
    end

    ctrl_step_decode u_decode (
        .i_state      (r_state),
        .i_opcode     (w_opcode),
        .i_con_ff     (con_ff),
        .o_out_sel    (w_out_sel),
        .o_reg_enable (w_reg_enable),
        .o_alu_sel    (w_alu_sel),
        .o_read       (w_read),
        .o_write      (w_write),
        .o_inc_pc     (w_inc_pc),
        .o_gra        (w_gra),
        .o_grb        (w_grb),
        .o_grc        (w_grc),
        .o_rin        (w_rin),
        .o_rout       (w_rout),
        .o_baout      (w_baout),
        .o_con_in     (w_con_in),
        .o_run        (w_run),
        .o_illegal_op (w_illegal_op)
    );

    // clr silences every strobe in the same cycle so an abandoned store never writes
    assign out_sel    = clr ? 32'd0 : w_out_sel;
    assign reg_enable = clr ? 32'd0 : w_reg_enable;
    assign ALU_Sel    = clr ? ALU_NONE : w_alu_sel;
    assign read       = clr ? 1'b0 : w_read;
    assign write      = clr ? 1'b0 : w_write;
    assign incPC      = clr ? 1'b0 : w_inc_pc;
    assign Gra        = clr ? 4'd0 : w_gra;
    assign Grb        = clr ? 4'd0 : w_grb;
    assign Grc        = clr ? 4'd0 : w_grc;
    assign Rin        = clr ? 1'b0 : w_rin;
    assign Rout       = clr ? 1'b0 : w_rout;
    assign BAout      = clr ? 1'b0 : w_baout;
    assign conIn      = clr ? 1'b0 : w_con_in;
    assign run        = clr ? 1'b1 : w_run;
    assign illegal_op = clr ? 1'b0 : w_illegal_op;
    assign step       = clr ? T0 : r_state;

endmodule
